// File: rtl/expr_pkg.sv
// Shared encodings for the expression-solver controller: FSM states,
// ALU op codes and operand mux select constants.
package expr_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_X = 3'd1,
    S_MUL_AX = 3'd2,
    S_ADD_B  = 3'd3,
    S_MUL_X  = 3'd4,
    S_ADD_C  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  localparam logic [1:0] M0_ZERO = 2'b00;
  localparam logic [1:0] M0_A    = 2'b01;
  localparam logic [1:0] M0_B    = 2'b10;
  localparam logic [1:0] M0_C    = 2'b11;

  localparam logic [1:0] M1_M0 = 2'b00;
  localparam logic [1:0] M1_X  = 2'b01;
  localparam logic [1:0] M1_S  = 2'b10;
  localparam logic [1:0] M1_H  = 2'b11;

  localparam logic [1:0] M2_X  = 2'b00;
  localparam logic [1:0] M2_M0 = 2'b01;
  localparam logic [1:0] M2_S  = 2'b10;
  localparam logic [1:0] M2_H  = 2'b11;

endpackage

// File: rtl/expr_ctrl_decode.sv
// Combinational map from controller state to the datapath control word
// {LX, LS, LH, H, M0, M1, M2}.
module expr_ctrl_decode
  import expr_pkg::*;
(
  input  state_t     state,
  output logic       LX,
  output logic       LS,
  output logic       LH,
  output logic       H,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2
);

  always_comb begin
    LX = 1'b0;
    LS = 1'b0;
    LH = 1'b0;
    H  = OP_ADD;
    M0 = M0_ZERO;
    M1 = M1_M0;
    M2 = M2_X;
    case (state)
      S_LOAD_X: LX = 1'b1;
      S_MUL_AX: begin
        LS = 1'b1; H = OP_MUL; M0 = M0_A; M1 = M1_M0; M2 = M2_X;
      end
      S_ADD_B: begin
        LS = 1'b1; H = OP_ADD; M0 = M0_B; M1 = M1_M0; M2 = M2_S;
      end
      S_MUL_X: begin
        LS = 1'b1; H = OP_MUL; M1 = M1_S; M2 = M2_X;
      end
      S_ADD_C: begin
        LS = 1'b1; H = OP_ADD; M0 = M0_C; M1 = M1_M0; M2 = M2_S;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/expr_controller.sv
// Horner-schedule sequencer computing S = A*X^2 + B*X + C on the operative
// datapath. Optional EXPR_OVF_ABORT_EN: overflow on any S load jumps to DONE.
module expr_controller
  import expr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       zero,
  input  logic       overflow,
  output logic       LX,
  output logic       LS,
  output logic       LH,
  output logic       H,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       busy,
  output logic       done,
  output logic       res_zero,
  output logic       error
);

  state_t state, state_next;

  expr_ctrl_decode u_decode (
    .state (state),
    .LX    (LX),
    .LS    (LS),
    .LH    (LH),
    .H     (H),
    .M0    (M0),
    .M1    (M1),
    .M2    (M2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      error    <= 1'b0;
      res_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && start)
        error <= 1'b0;
      else if (LS && overflow)
        error <= 1'b1;
      if (state == S_DONE)
        res_zero <= zero;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_LOAD_X;
      S_LOAD_X: state_next = S_MUL_AX;
      S_MUL_AX: state_next = S_ADD_B;
      S_ADD_B:  state_next = S_MUL_X;
      S_MUL_X:  state_next = S_ADD_C;
      S_ADD_C:  state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
`ifdef EXPR_OVF_ABORT_EN
    if (LS && overflow)
      state_next = S_DONE;
`endif
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_expr_controller.sv
// Bench for expr_controller: drives a behavioural datapath from the DUT's
// control word and checks results against a step-wise arithmetic model.
module tb_expr_controller;

  logic       clk = 1'b0;
  logic       rst, start, zero, overflow;
  logic       LX, LS, LH, H, busy, done, res_zero, error;
  logic [1:0] M0, M1, M2;

  expr_controller dut (
    .clk(clk), .rst(rst), .start(start), .zero(zero), .overflow(overflow),
    .LX(LX), .LS(LS), .LH(LH), .H(H), .M0(M0), .M1(M1), .M2(M2),
    .busy(busy), .done(done), .res_zero(res_zero), .error(error)
  );

  always #5 clk = ~clk;

`ifdef EXPR_OVF_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  // operative datapath model
  logic [15:0] in_a, in_b, in_c, in_x;
  logic [15:0] reg_x, reg_s, reg_h;
  logic [15:0] m0_out, op_a, op_b;
  logic [31:0] alu;

  always_comb begin
    m0_out = (M0 == 2'b00) ? 16'h0 : (M0 == 2'b01) ? in_a : (M0 == 2'b10) ? in_b : in_c;
    op_b   = (M1 == 2'b00) ? m0_out : (M1 == 2'b01) ? reg_x : (M1 == 2'b10) ? reg_s : reg_h;
    op_a   = (M2 == 2'b00) ? reg_x : (M2 == 2'b01) ? m0_out : (M2 == 2'b10) ? reg_s : reg_h;
    alu    = H ? (32'(op_a) * 32'(op_b)) : (32'(op_a) + 32'(op_b));
    overflow = |alu[31:16];
    zero     = (reg_s == 16'h0);
  end

  initial begin
    reg_x = '0; reg_s = '0; reg_h = '0;
  end

  always @(posedge clk) begin
    if (LX) reg_x <= in_x;
    if (LS) reg_s <= alu[15:0];
    if (LH) reg_h <= alu[15:0];
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: four truncating steps, overflow noted on the untruncated value.
  task automatic ref_eval(input int unsigned a, b, c, x,
                          output int unsigned s, output bit err, output int unsigned lat);
    longint unsigned t;
    longint unsigned operand [4];
    s = 0; err = 1'b0; lat = 6;
    operand[0] = longint'(x); operand[1] = longint'(b);
    operand[2] = longint'(x); operand[3] = longint'(c);
    for (int i = 0; i < 4; i++) begin
      if (i == 0)          t = longint'(a) * operand[0];
      else if (i % 2 == 0) t = longint'(s) * operand[i];
      else                 t = longint'(s) + operand[i];
      s = int'(t & 64'hFFFF);
      if (t > 64'hFFFF) begin
        err = 1'b1;
        if (ABORT_EN) begin
          lat = 32'(i) + 3;
          return;
        end
      end
    end
  endtask

  function automatic logic [9:0] exp_ctrl(input int unsigned cyc);
    case (cyc)
      1:       return {4'b1000, 2'b00, 2'b00, 2'b00};
      2:       return {4'b0101, 2'b01, 2'b00, 2'b00};
      3:       return {4'b0100, 2'b10, 2'b00, 2'b10};
      4:       return {4'b0101, 2'b00, 2'b10, 2'b00};
      5:       return {4'b0100, 2'b11, 2'b00, 2'b10};
      default: return '0;
    endcase
  endfunction

  function automatic logic [9:0] ctrl_word();
    return {LX, LS, LH, H, M0, M1, M2};
  endfunction

  task automatic run_eval(input logic [15:0] a, b, c, x, input string tag);
    int unsigned es, elat, cyc;
    bit eerr;
    ref_eval(32'(a), 32'(b), 32'(c), 32'(x), es, eerr, elat);
    in_a = a; in_b = b; in_c = c; in_x = x;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      check({tag, "_ctl"}, 32'(ctrl_word()), 32'(exp_ctrl(cyc)));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, elat);
    if (done) begin
      check({tag, "_result"}, 32'(reg_s), es);
      check({tag, "_err_at_done"}, 32'(error), 32'(eerr));
      check({tag, "_ctl_done"}, 32'(ctrl_word()), 32'd0);
    end
    @(posedge clk); #1;
    check({tag, "_res_zero"}, 32'(res_zero), 32'(es == 0));
    check({tag, "_err_hold"}, 32'(error), 32'(eerr));
    check({tag, "_idle"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    int unsigned cnt, low;
    rst = 1'b1; start = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_x = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", 32'(ctrl_word()), 32'd0);
    check("rst_flags", 32'({busy, done, res_zero, error}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_eval(16'd2, 16'd4, 16'd5, 16'd3, "basic");
    run_eval(16'd7, 16'd9, 16'd0, 16'd0, "zero");
    run_eval(16'h1000, 16'd0, 16'd0, 16'd255, "ovf");
    run_eval(16'd2, 16'd4, 16'd5, 16'd3, "err_clear");

    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0)
        run_eval(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), "rand_wide");
      else
        run_eval(16'($urandom_range(0, 20)), 16'($urandom_range(0, 50)),
                 16'($urandom_range(0, 50)), 16'($urandom_range(0, 20)), "rand_small");
    end

    // start held high: one idle cycle between back-to-back runs
    in_a = 16'd1; in_b = 16'd2; in_c = 16'd3; in_x = 16'd4;
    start = 1'b1;
    cnt = 0;
    while (!done && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("held_first_done", 32'(done), 32'd1);
    for (int r = 0; r < 2; r++) begin
      cnt = 0; low = 0;
      do begin
        @(posedge clk); #1;
        cnt++;
        if (!busy) low++;
      end while (!done && cnt < 20);
      check("held_period", cnt, 32'd7);
      check("held_busy_low", low, 32'd1);
      check("held_result", 32'(reg_s), 32'd27);
    end
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // reset while in MUL_X
    in_a = 16'd3; in_b = 16'd3; in_c = 16'd3; in_x = 16'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mulx_reached", 32'(ctrl_word()), 32'(exp_ctrl(4)));
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ctl", 32'(ctrl_word()), 32'd0);
    check("midrst_flags", 32'({busy, done, error}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_stay_idle", 32'({busy, LS, LX}), 32'd0);
    run_eval(16'd1, 16'd1, 16'd1, 16'd2, "after_rst");
    check("after_rst_seven", 32'(reg_s), 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  always @(negedge clk) begin
    if (LH) begin
      n_checks++;
      $display("FAIL lh_never: got 1 expected 0");
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
